// File: rtl/instr_encoder_loader_if.sv
// Decoded-instruction beat stream into the program loader.
// The master drives fields and in_valid; the slave returns in_ready.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [20:0] imm;
    logic        last;

    modport master (
        output in_valid, op, rd, rs1, rs2,
        output funct3, funct7, imm, last,
        input  in_ready
    );

    modport slave (
        input  in_valid, op, rd, rs1, rs2,
        input  funct3, funct7, imm, last,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Re-encodes decoded RV32I beats and writes them into instruction memory.
// Holds the core in reset while loading or after a rejected beat.
module instr_encoder_loader #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    instr_encoder_loader_if.slave s,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [XLEN-1:0]       imem_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   wr_count
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LP_TOP  = '1;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [XLEN-1:0]       r_wdata;

    logic [31:0] w_enc;
    logic        w_bad;
    logic        w_accept;
    logic        w_shift;
    logic        w_i_ovf;
    logic        w_b_ovf;

    assign w_accept = s.in_valid && s.in_ready && !start;
    assign w_shift  = (s.op == 7'b0010011) && (s.funct3[1:0] == 2'b01);
    assign w_i_ovf  = !((&s.imm[20:11]) || !(|s.imm[20:11]));
    assign w_b_ovf  = !((&s.imm[20:12]) || !(|s.imm[20:12]));

    // Field packing per instruction format and legality of the beat.
    always_comb begin
        w_enc = '0;
        w_bad = 1'b0;
        case (s.op)
            7'b0110011, 7'b0111011: begin
                w_enc = {s.funct7, s.rs2, s.rs1, s.funct3, s.rd, s.op};
            end
            7'b0000011, 7'b0010011: begin
                if (w_shift) begin
                    w_enc = {s.funct7, s.imm[4:0], s.rs1,
                             s.funct3, s.rd, s.op};
                end else begin
                    w_enc = {s.imm[11:0], s.rs1, s.funct3, s.rd, s.op};
                    w_bad = w_i_ovf;
                end
            end
            7'b0100011: begin
                w_enc = {s.imm[11:5], s.rs2, s.rs1, s.funct3,
                         s.imm[4:0], s.op};
                w_bad = w_i_ovf;
            end
            7'b1100011: begin
                w_enc = {s.imm[12], s.imm[10:5], s.rs2, s.rs1, s.funct3,
                         s.imm[4:1], s.imm[11], s.op};
                w_bad = w_b_ovf || s.imm[0];
            end
            7'b1101111: begin
                w_enc = {s.imm[20], s.imm[10:1], s.imm[11],
                         s.imm[19:12], s.rd, s.op};
                w_bad = s.imm[0];
            end
            default: w_bad = 1'b1;
        endcase
    end

    // Next-state: start always wins, then the accepted beat decides.
    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = LOAD;
        end else if (w_accept) begin
            if (w_bad)
                w_next = ERROR;
            else if (s.last)
                w_next = DONE;
            else if (r_ptr == LP_TOP)
                w_next = ERROR;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Write pointer, count and one-cycle-delayed memory write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= LP_BASE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= LP_BASE;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (start) begin
                r_ptr <= LP_BASE;
                r_cnt <= '0;
            end else if (w_accept && !w_bad) begin
                r_we    <= 1'b1;
                r_addr  <= r_ptr;
                r_wdata <= XLEN'(w_enc);
                r_cnt   <= r_cnt + 1'b1;
                if (r_ptr != LP_TOP)
                    r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign s.in_ready  = (r_state == LOAD);
    assign busy        = (r_state == LOAD);
    assign done        = (r_state == DONE);
    assign err         = (r_state == ERROR);
    assign core_hold   = (r_state == LOAD) || (r_state == ERROR);
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign wr_count    = r_cnt;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader against an arithmetic model.
// Writes are captured per cycle and compared to the model's write list.
module tb_instr_encoder_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       imem_we;
    logic [8:0] imem_addr;
    logic [31:0] imem_wdata;
    logic       core_hold;
    logic       busy;
    logic       done;
    logic       err;
    logic [9:0] wr_count;

    instr_encoder_loader_if s();

    instr_encoder_loader #(
        .XLEN(32), .ADDR_WIDTH(9), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s(s),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_hold(core_hold),
        .busy(busy), .done(done), .err(err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [20:0] imm;
        logic        last;
    } beat_t;

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    wr_t got[$];
    wr_t exp[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (imem_we === 1'b1) begin
            w.a = imem_addr;
            w.d = imem_wdata;
            w.c = cyc;
            got.push_back(w);
        end
    end

    // Reference encoder: fields placed by weight, legality by value range.
    function automatic bit model_enc(input beat_t b, output logic [31:0] w);
        longint unsigned u  = b.imm;
        longint signed   sv = (u >= 1048576) ? longint'(u) - 2097152
                                             : longint'(u);
        longint unsigned rd = b.rd;
        longint unsigned s1 = b.rs1;
        longint unsigned s2 = b.rs2;
        longint unsigned f3 = b.f3;
        longint unsigned f7 = b.f7;
        longint unsigned op = b.op;
        longint unsigned base;
        longint unsigned acc = 0;
        bit ok = 1'b1;
        base = s1 * 32768 + f3 * 4096 + op;
        case (b.op)
            7'h33, 7'h3B:
                acc = f7 * 33554432 + s2 * 1048576 + base + rd * 128;
            7'h03, 7'h13: begin
                if (b.op == 7'h13 && (f3 == 1 || f3 == 5)) begin
                    acc = f7 * 33554432 + (u % 32) * 1048576
                        + base + rd * 128;
                end else begin
                    ok  = (sv >= -2048) && (sv <= 2047);
                    acc = (u % 4096) * 1048576 + base + rd * 128;
                end
            end
            7'h23: begin
                ok  = (sv >= -2048) && (sv <= 2047);
                acc = ((u / 32) % 128) * 33554432 + s2 * 1048576
                    + base + (u % 32) * 128;
            end
            7'h63: begin
                ok  = (sv >= -4096) && (sv <= 4095) && (u % 2 == 0);
                acc = ((u / 4096) % 2) * 64'h80000000
                    + ((u / 32) % 64) * 33554432 + s2 * 1048576 + base
                    + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128;
            end
            7'h6F: begin
                ok  = (u % 2 == 0);
                acc = ((u / 1048576) % 2) * 64'h80000000
                    + ((u / 2) % 1024) * 2097152
                    + ((u / 2048) % 2) * 1048576
                    + ((u / 4096) % 256) * 4096 + rd * 128 + op;
            end
            default: ok = 1'b0;
        endcase
        w = acc[31:0];
        return ok;
    endfunction

    function automatic beat_t mk(
        input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] f3, input int imm, input logic lst
    );
        beat_t b;
        b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
        b.f3 = f3; b.f7 = 7'h0; b.imm = imm[20:0]; b.last = lst;
        return b;
    endfunction

    function automatic beat_t rand_beat(input bit allow_bad);
        beat_t b;
        int v;
        b.rd = 5'($urandom); b.rs1 = 5'($urandom);
        b.rs2 = 5'($urandom); b.f3 = 3'($urandom);
        b.f7 = 7'($urandom); b.last = 1'b0;
        case ($urandom_range(0, 6))
            0: b.op = 7'h33;
            1: b.op = 7'h3B;
            2: b.op = 7'h03;
            3: b.op = 7'h13;
            4: b.op = 7'h23;
            5: b.op = 7'h63;
            default: b.op = 7'h6F;
        endcase
        if (b.op == 7'h63)
            v = (int'($urandom_range(0, 4095)) - 2048) * 2;
        else if (b.op == 7'h6F)
            v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        else
            v = int'($urandom_range(0, 4095)) - 2048;
        b.imm = v[20:0];
        if (allow_bad && $urandom_range(0, 24) == 0) begin
            case ($urandom_range(0, 2))
                0: b.op = 7'h37;
                1: begin b.op = 7'h63; v = 5001; b.imm = v[20:0]; end
                default: begin
                    b.op = 7'h23; b.f3 = 3'd2; v = -3000;
                    b.imm = v[20:0];
                end
            endcase
        end
        return b;
    endfunction

    task automatic put(input beat_t b);
        s.in_valid = 1'b1;
        s.op = b.op; s.rd = b.rd; s.rs1 = b.rs1; s.rs2 = b.rs2;
        s.funct3 = b.f3; s.funct7 = b.f7; s.imm = b.imm;
        s.last = b.last;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        s.in_valid = 1'b0;
        s.last = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start;
        got.delete();
        exp.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({s.in_ready, imem_we, core_hold, busy, done, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=000000",
                     {s.in_ready, imem_we, core_hold, busy, done, err});
        end
        n_tests++;
        if ({imem_addr, imem_wdata, wr_count} !== 51'b0) begin
            n_fail++;
            $display("FAIL reset_bus addr=%0d wdata=%h cnt=%0d want 0",
                     imem_addr, imem_wdata, wr_count);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_single;
        pulse_start();
        n_tests++;
        if ({busy, core_hold, s.in_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL single_load got=%b want=111",
                     {busy, core_hold, s.in_ready});
        end
        put(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 5, 1'b1));
        s.in_valid = 1'b0;
        n_tests++;
        if ({done, core_hold, s.in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_done got=%b want=100",
                     {done, core_hold, s.in_ready});
        end
        idle(1);
        n_tests++;
        if (got.size() != 1 || got[0].a !== 9'd0 ||
            got[0].d !== 32'h00500093) begin
            n_fail++;
            $display("FAIL single_write n=%0d want 1 x 0@00500093",
                     got.size());
        end
        n_tests++;
        if (wr_count !== 10'd1) begin
            n_fail++;
            $display("FAIL single_count got=%0d want=1", wr_count);
        end
    endtask

    task automatic test_back_to_back;
        pulse_start();
        put(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 0, 1'b0));
        put(mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 8, 1'b0));
        put(mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -8, 1'b1));
        idle(2);
        n_tests++;
        if (got.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d want=3", got.size());
        end else begin
            n_tests++;
            if (got[0].d !== 32'h002081B3 || got[1].d !== 32'h0020A423 ||
                got[2].d !== 32'hFE208CE3) begin
                n_fail++;
                $display("FAIL b2b_data got=%h %h %h want=%s",
                         got[0].d, got[1].d, got[2].d,
                         "002081b3 0020a423 fe208ce3");
            end
            n_tests++;
            if (got[0].a !== 9'd0 || got[1].a !== 9'd1 ||
                got[2].a !== 9'd2) begin
                n_fail++;
                $display("FAIL b2b_addr got=%0d %0d %0d want=0 1 2",
                         got[0].a, got[1].a, got[2].a);
            end
            n_tests++;
            if (got[1].c != got[0].c + 1 || got[2].c != got[0].c + 2) begin
                n_fail++;
                $display("FAIL b2b_cycles got=%0d %0d %0d want consecutive",
                         got[0].c, got[1].c, got[2].c);
            end
        end
        n_tests++;
        if ({done, core_hold, wr_count} !== {2'b10, 10'd3}) begin
            n_fail++;
            $display("FAIL b2b_done done=%b hold=%b cnt=%0d want 1 0 3",
                     done, core_hold, wr_count);
        end
    endtask

    task automatic test_jal_err;
        pulse_start();
        put(mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 16, 1'b0));
        put(mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 17, 1'b0));
        s.in_valid = 1'b0;
        n_tests++;
        if ({err, core_hold, s.in_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL jal_err got=%b want=110",
                     {err, core_hold, s.in_ready});
        end
        idle(2);
        n_tests++;
        if (got.size() != 1 || got[0].d !== 32'h010000EF ||
            wr_count !== 10'd1) begin
            n_fail++;
            $display("FAIL jal_write n=%0d cnt=%0d want 1 x 010000ef",
                     got.size(), wr_count);
        end
        pulse_start();
        n_tests++;
        if ({err, busy, wr_count} !== {2'b01, 10'd0}) begin
            n_fail++;
            $display("FAIL jal_restart err=%b busy=%b cnt=%0d want 0 1 0",
                     err, busy, wr_count);
        end
    endtask

    task automatic test_illegal;
        pulse_start();
        put(mk(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 0, 1'b0));
        idle(2);
        n_tests++;
        if (err !== 1'b1 || got.size() != 0) begin
            n_fail++;
            $display("FAIL bad_op err=%b writes=%0d want 1 0",
                     err, got.size());
        end
        pulse_start();
        put(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 2048, 1'b0));
        idle(2);
        n_tests++;
        if (err !== 1'b1 || got.size() != 0) begin
            n_fail++;
            $display("FAIL imm_range err=%b writes=%0d want 1 0",
                     err, got.size());
        end
    endtask

    task automatic test_fill;
        beat_t b;
        wr_t e;
        int bad = 0;
        pulse_start();
        for (int i = 0; i < 512; i++) begin
            b = rand_beat(1'b0);
            void'(model_enc(b, e.d));
            e.a = 9'(i);
            e.c = 0;
            exp.push_back(e);
            put(b);
        end
        idle(2);
        n_tests++;
        if (got.size() != 512) begin
            n_fail++;
            $display("FAIL fill_count got=%0d want=512", got.size());
        end else begin
            for (int i = 0; i < 512; i++)
                if (got[i].a !== exp[i].a || got[i].d !== exp[i].d)
                    bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL fill_data mismatches=%0d want=0", bad);
            end
        end
        n_tests++;
        if (err !== 1'b1 || core_hold !== 1'b1 || wr_count !== 10'd512) begin
            n_fail++;
            $display("FAIL fill_end err=%b hold=%b cnt=%0d want 1 1 512",
                     err, core_hold, wr_count);
        end
    endtask

    task automatic test_random;
        beat_t b;
        wr_t e;
        int n;
        int bad;
        bit ok;
        bit want_err;
        for (int r = 0; r < 8; r++) begin
            pulse_start();
            n = $urandom_range(10, 40);
            want_err = 1'b0;
            bad = 0;
            for (int i = 0; i < n; i++) begin
                b = rand_beat(1'b1);
                b.last = (i == n - 1);
                ok = model_enc(b, e.d);
                put(b);
                if (!ok) begin
                    want_err = 1'b1;
                    break;
                end
                e.a = 9'(exp.size());
                e.c = 0;
                exp.push_back(e);
            end
            idle(2);
            n_tests++;
            if (got.size() != exp.size()) begin
                n_fail++;
                $display("FAIL rand_count run=%0d got=%0d want=%0d",
                         r, got.size(), exp.size());
            end else begin
                foreach (exp[i])
                    if (got[i].a !== exp[i].a || got[i].d !== exp[i].d)
                        bad++;
                n_tests++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL rand_data run=%0d mismatches=%0d want=0",
                             r, bad);
                end
            end
            n_tests++;
            if (err !== want_err || done !== !want_err ||
                wr_count !== 10'(exp.size())) begin
                n_fail++;
                $display("FAIL rand_end run=%0d err=%b done=%b cnt=%0d %s%0d",
                         r, err, done, wr_count, "want cnt=", exp.size());
            end
        end
    endtask

    task automatic test_reset_mid;
        beat_t b;
        pulse_start();
        put(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 0, 1'b0));
        put(mk(7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 0, 1'b0));
        b = mk(7'h33, 5'd5, 5'd1, 5'd2, 3'd0, 0, 1'b0);
        rst_n = 1'b0;
        put(b);
        n_tests++;
        if ({s.in_ready, imem_we, core_hold, busy, done, err,
             imem_addr, imem_wdata, wr_count} !== 57'b0) begin
            n_fail++;
            $display("FAIL midrst_out we=%b hold=%b busy=%b cnt=%0d %s",
                     imem_we, core_hold, busy, wr_count, "want all 0");
        end
        rst_n = 1'b1;
        put(b);
        put(b);
        idle(1);
        n_tests++;
        if (got.size() != 2) begin
            n_fail++;
            $display("FAIL midrst_writes got=%0d want=2", got.size());
        end
    endtask

    task automatic test_start_priority;
        got.delete();
        s.in_valid = 1'b1;
        s.op = 7'h33; s.rd = 5'd1; s.rs1 = 5'd2; s.rs2 = 5'd3;
        s.funct3 = 3'd0; s.funct7 = 7'd0; s.imm = 21'd0;
        s.last = 1'b1;
        idle(0);
        s.in_valid = 1'b1;
        s.last = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s.in_valid = 1'b0;
        s.last = 1'b0;
        idle(2);
        n_tests++;
        if (got.size() != 0 || wr_count !== 10'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_prio writes=%0d cnt=%0d busy=%b %s",
                     got.size(), wr_count, busy, "want 0 0 1");
        end
    endtask

    initial begin
        s.in_valid = 1'b0;
        s.op = '0; s.rd = '0; s.rs1 = '0; s.rs2 = '0;
        s.funct3 = '0; s.funct7 = '0; s.imm = '0; s.last = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_jal_err();
        test_illegal();
        test_fill();
        test_random();
        test_reset_mid();
        test_start_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
